// File: rtl/frame_scheduler.sv
// Frame scheduler for a double-buffered display pipeline.
// Clears the back buffer at each vblank, then hands the buffer to the drawing
// engine. Once the engine reports completion, the buffers are swapped on the
// next vblank rising edge. A vblank that arrives before the frame is finished
// is reported as an overrun, and no swap takes place on that edge.
module frame_scheduler #(
   parameter int unsigned    W        = 320,
   parameter int unsigned    H        = 240,
   parameter int unsigned    DW       = 8,
   parameter logic [DW-1:0]  BG_COLOR = 8'h00
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          vblank,
   input  logic [9:0]    draw_x,
   input  logic [9:0]    draw_y,
   input  logic [DW-1:0] draw_color,
   input  logic          draw_we,
   input  logic          draw_done,
   output logic [9:0]    fb_x,
   output logic [9:0]    fb_y,
   output logic [DW-1:0] fb_color,
   output logic          fb_we,
   output logic          buffer_sel,
   output logic          draw_go,
   output logic          overrun,
   output logic [15:0]   frame_count
);

   localparam logic [9:0] X_LAST = 10'(W - 1);
   localparam logic [9:0] Y_LAST = 10'(H - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CLEAR   = 2'd1,
      S_DRAW    = 2'd2,
      S_WAIT_VB = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [9:0]     cx_q, cx_d;
   logic [9:0]     cy_q, cy_d;
   logic           buffer_sel_q, buffer_sel_d;
   logic [15:0]    frame_count_q, frame_count_d;
   logic           draw_go_q, draw_go_d;
   logic           overrun_q, overrun_d;
   logic [9:0]     fb_x_q, fb_x_d;
   logic [9:0]     fb_y_q, fb_y_d;
   logic [DW-1:0]  fb_color_q, fb_color_d;
   logic           vb_h1_q, vb_h1_d;
   logic           vb_h2_q, vb_h2_d;
   logic           primed_q, primed_d;
   logic           vb_edge;

   // The first clock after reset loads both history flops from vblank, so a
   // level that is already high at release is not mistaken for a rising edge.
   always_comb begin
      vb_h1_d  = vblank;
      vb_h2_d  = primed_q ? vb_h1_q : vblank;
      primed_d = 1'b1;
      vb_edge  = vb_h1_q & ~vb_h2_q;
   end

   // Sequencing, clear-address generation and framebuffer port mux.
   always_comb begin
      state_d       = state_q;
      cx_d          = cx_q;
      cy_d          = cy_q;
      buffer_sel_d  = buffer_sel_q;
      frame_count_d = frame_count_q;
      draw_go_d     = 1'b0;
      overrun_d     = 1'b0;
      fb_x          = fb_x_q;
      fb_y          = fb_y_q;
      fb_color      = fb_color_q;
      fb_we         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (vb_edge) begin
               state_d = S_CLEAR;
               cx_d    = '0;
               cy_d    = '0;
            end
         end

         S_CLEAR: begin
            fb_we    = 1'b1;
            fb_x     = cx_q;
            fb_y     = cy_q;
            fb_color = BG_COLOR;
            if (vb_edge) begin
               overrun_d = 1'b1;
            end
            if (cx_q == X_LAST) begin
               cx_d = '0;
               if (cy_q == Y_LAST) begin
                  cy_d      = '0;
                  state_d   = S_DRAW;
                  draw_go_d = 1'b1;
               end else begin
                  cy_d = cy_q + 10'd1;
               end
            end else begin
               cx_d = cx_q + 10'd1;
            end
         end

         S_DRAW: begin
            fb_x     = draw_x;
            fb_y     = draw_y;
            fb_color = draw_color;
            fb_we    = draw_we;
            if (vb_edge) begin
               overrun_d = 1'b1;
            end
            if (draw_done) begin
               state_d = S_WAIT_VB;
            end
         end

         S_WAIT_VB: begin
            if (vb_edge) begin
               state_d       = S_CLEAR;
               buffer_sel_d  = ~buffer_sel_q;
               frame_count_d = frame_count_q + 16'd1;
               cx_d          = '0;
               cy_d          = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      fb_x_d     = fb_x;
      fb_y_d     = fb_y;
      fb_color_d = fb_color;
   end

   // State, counters, registered pulses and the held framebuffer address/colour.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= S_IDLE;
         cx_q          <= '0;
         cy_q          <= '0;
         buffer_sel_q  <= 1'b0;
         frame_count_q <= '0;
         draw_go_q     <= 1'b0;
         overrun_q     <= 1'b0;
         fb_x_q        <= '0;
         fb_y_q        <= '0;
         fb_color_q    <= '0;
         vb_h1_q       <= 1'b0;
         vb_h2_q       <= 1'b0;
         primed_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cx_q          <= cx_d;
         cy_q          <= cy_d;
         buffer_sel_q  <= buffer_sel_d;
         frame_count_q <= frame_count_d;
         draw_go_q     <= draw_go_d;
         overrun_q     <= overrun_d;
         fb_x_q        <= fb_x_d;
         fb_y_q        <= fb_y_d;
         fb_color_q    <= fb_color_d;
         vb_h1_q       <= vb_h1_d;
         vb_h2_q       <= vb_h2_d;
         primed_q      <= primed_d;
      end
   end

   assign buffer_sel  = buffer_sel_q;
   assign frame_count = frame_count_q;
   assign draw_go     = draw_go_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler on a reduced 8x4 frame.
module tb_frame_scheduler;

   localparam int unsigned TW  = 8;
   localparam int unsigned TH  = 4;
   localparam logic [7:0]  BG  = 8'h5A;

   logic        Clk;
   logic        Reset_n;
   logic        vblank;
   logic [9:0]  draw_x;
   logic [9:0]  draw_y;
   logic [7:0]  draw_color;
   logic        draw_we;
   logic        draw_done;
   logic [9:0]  fb_x;
   logic [9:0]  fb_y;
   logic [7:0]  fb_color;
   logic        fb_we;
   logic        buffer_sel;
   logic        draw_go;
   logic        overrun;
   logic [15:0] frame_count;

   int n_chk;
   int n_err;

   frame_scheduler #(
      .W        (TW),
      .H        (TH),
      .DW       (8),
      .BG_COLOR (BG)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .vblank      (vblank),
      .draw_x      (draw_x),
      .draw_y      (draw_y),
      .draw_color  (draw_color),
      .draw_we     (draw_we),
      .draw_done   (draw_done),
      .fb_x        (fb_x),
      .fb_y        (fb_y),
      .fb_color    (fb_color),
      .fb_we       (fb_we),
      .buffer_sel  (buffer_sel),
      .draw_go     (draw_go),
      .overrun     (overrun),
      .frame_count (frame_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Low for one clock, then rise; returns one clock after the edge was acted on.
   task automatic vb_rise();
      vblank = 1'b0;
      tick();
      vblank = 1'b1;
      tick();
      tick();
   endtask

   // Walk the clear from pixel index start to the end, then expect draw_go.
   task automatic run_clear(input int start);
      for (int i = start; i < int'(TW * TH); i++) begin
         chk("clr_we",  32'(fb_we),    32'd1);
         chk("clr_x",   32'(fb_x),     32'(i % TW));
         chk("clr_y",   32'(fb_y),     32'(i / TW));
         chk("clr_col", 32'(fb_color), 32'(BG));
         chk("clr_go",  32'(draw_go),  32'd0);
         tick();
      end
      chk("draw_go",      32'(draw_go), 32'd1);
      tick();
      chk("draw_go_once", 32'(draw_go), 32'd0);
   endtask

   initial begin
      n_chk      = 0;
      n_err      = 0;
      Reset_n    = 1'b0;
      vblank     = 1'b0;
      draw_x     = '0;
      draw_y     = '0;
      draw_color = '0;
      draw_we    = 1'b0;
      draw_done  = 1'b0;

      // Reset state
      #1;
      chk("rst_we",   32'(fb_we),       32'd0);
      chk("rst_x",    32'(fb_x),        32'd0);
      chk("rst_bsel", 32'(buffer_sel),  32'd0);
      chk("rst_fc",   32'(frame_count), 32'd0);
      chk("rst_go",   32'(draw_go),     32'd0);
      chk("rst_ovr",  32'(overrun),     32'd0);
      tick();
      tick();
      Reset_n = 1'b1;
      tick();

      // IDLE ignores the drawing engine
      draw_we   = 1'b1;
      draw_done = 1'b1;
      draw_x    = 10'd9;
      #1;
      chk("idle_we", 32'(fb_we), 32'd0);
      chk("idle_x",  32'(fb_x),  32'd0);
      tick();
      chk("idle_go", 32'(draw_go), 32'd0);
      draw_we   = 1'b0;
      draw_done = 1'b0;
      draw_x    = '0;

      // First frame: clear then draw
      vb_rise();
      run_clear(0);
      draw_x     = 10'd5;
      draw_y     = 10'd7;
      draw_color = 8'h3C;
      draw_we    = 1'b1;
      #1;
      chk("draw_x",   32'(fb_x),     32'd5);
      chk("draw_y",   32'(fb_y),     32'd7);
      chk("draw_col", 32'(fb_color), 32'h3C);
      chk("draw_we",  32'(fb_we),    32'd1);
      tick();
      draw_we   = 1'b0;
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;

      // WAIT_VB holds the last address and ignores draw_*
      draw_x  = 10'd9;
      draw_we = 1'b1;
      #1;
      chk("wait_we",   32'(fb_we),    32'd0);
      chk("wait_x",    32'(fb_x),     32'd5);
      chk("wait_y",    32'(fb_y),     32'd7);
      chk("wait_col",  32'(fb_color), 32'h3C);
      draw_we = 1'b0;
      draw_x  = 10'd5;
      vb_rise();
      chk("swap1_bsel", 32'(buffer_sel),  32'd1);
      chk("swap1_fc",   32'(frame_count), 32'd1);
      run_clear(0);

      // Overrun in DRAW: no swap
      vb_rise();
      chk("ovr_draw",      32'(overrun),     32'd1);
      chk("ovr_draw_bsel", 32'(buffer_sel),  32'd1);
      chk("ovr_draw_fc",   32'(frame_count), 32'd1);
      draw_we = 1'b1;
      #1;
      chk("ovr_still_draw", 32'(fb_we), 32'd1);
      draw_we = 1'b0;
      tick();
      chk("ovr_draw_once", 32'(overrun), 32'd0);
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      vb_rise();
      chk("swap2_bsel", 32'(buffer_sel),  32'd0);
      chk("swap2_fc",   32'(frame_count), 32'd2);

      // Overrun in CLEAR: clear keeps running
      vb_rise();
      chk("ovr_clr",      32'(overrun),     32'd1);
      chk("ovr_clr_fc",   32'(frame_count), 32'd2);
      chk("ovr_clr_bsel", 32'(buffer_sel),  32'd0);
      run_clear(3);

      // draw_done coincident with the vblank edge
      vblank = 1'b0;
      tick();
      vblank = 1'b1;
      tick();
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      draw_we   = 1'b1;
      #1;
      chk("coin_ovr",  32'(overrun),     32'd1);
      chk("coin_we",   32'(fb_we),       32'd0);
      chk("coin_bsel", 32'(buffer_sel),  32'd0);
      chk("coin_fc",   32'(frame_count), 32'd2);
      draw_we = 1'b0;
      vb_rise();
      chk("swap3_bsel", 32'(buffer_sel),  32'd1);
      chk("swap3_fc",   32'(frame_count), 32'd3);

      // Reset mid-CLEAR at (4,2) with vblank held high
      for (int i = 0; i < 20; i++) tick();
      chk("pre_rst_x", 32'(fb_x), 32'd4);
      chk("pre_rst_y", 32'(fb_y), 32'd2);
      Reset_n = 1'b0;
      #1;
      chk("mrst_we",   32'(fb_we),       32'd0);
      chk("mrst_x",    32'(fb_x),        32'd0);
      chk("mrst_y",    32'(fb_y),        32'd0);
      chk("mrst_col",  32'(fb_color),    32'd0);
      chk("mrst_bsel", 32'(buffer_sel),  32'd0);
      chk("mrst_fc",   32'(frame_count), 32'd0);
      chk("mrst_go",   32'(draw_go),     32'd0);
      chk("mrst_ovr",  32'(overrun),     32'd0);
      tick();
      Reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_idle", 32'(fb_we), 32'd0);
      end
      vblank = 1'b0;
      tick();
      vblank = 1'b1;
      tick();
      tick();
      run_clear(0);
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;

      // frame_count wrap
      force dut.frame_count_q = 16'hFFFF;
      tick();
      release dut.frame_count_q;
      vb_rise();
      chk("wrap_fc",   32'(frame_count), 32'd0);
      chk("wrap_bsel", 32'(buffer_sel),  32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter W, default 320, frame width in pixels.
REQ-002 SHALL have parameter H, default 240, frame height in pixels.
REQ-003 SHALL have parameter DW, default 8, palette index width.
REQ-004 SHALL have parameter BG_COLOR, default 8'h00, clear colour index.
REQ-005 SHALL have ports, clock and reset first:
- Clk  in  1  sole clock.
- Reset_n  in  1  asynchronous, active-low reset.
- vblank  in  1  level, high during vertical blank.
- draw_x  in  10  drawing-engine write column.
- draw_y  in  10  drawing-engine write row.
- draw_color  in  DW  drawing-engine write colour.
- draw_we  in  1  drawing-engine write strobe.
- draw_done  in  1  one-cycle pulse, engine finished the frame.
- fb_x  out  10  framebuffer write column.
- fb_y  out  10  framebuffer write row.
- fb_color  out  DW  framebuffer write colour.
- fb_we  out  1  framebuffer write enable.
- buffer_sel  out  1  back buffer index being written; display reads ~buffer_sel.
- draw_go  out  1  one-cycle pulse, engine may start the frame.
- overrun  out  1  one-cycle pulse, vblank edge missed because the frame was unfinished.
- frame_count  out  16  completed buffer swaps.

Function
REQ-006 SHALL detect the vblank rising edge with a two-flop history; vb_edge is high for exactly one cycle per edge.
REQ-007 SHALL implement states IDLE, CLEAR, DRAW and WAIT_VB.
REQ-008 IDLE: on vb_edge, go to CLEAR with clear counters at (0,0).
REQ-009 CLEAR: fb_we=1, fb_color=BG_COLOR, fb_x/fb_y equal to the clear counters; x increments each cycle and wraps W-1 to 0 with y+1.
REQ-010 CLEAR SHALL last exactly W*H cycles; on the cycle after (W-1,H-1) is written, pulse draw_go and enter DRAW.
REQ-011 DRAW: fb_x/fb_y/fb_color/fb_we pass draw_* through combinationally with zero latency; draw_* SHALL be ignored in all other states.
REQ-012 DRAW: draw_done SHALL move the block to WAIT_VB.
REQ-013 WAIT_VB: on vb_edge, toggle buffer_sel, increment frame_count (16-bit, wraps 0xFFFF to 0), clear counters to (0,0), and enter CLEAR.
REQ-014 A vb_edge seen in CLEAR or DRAW SHALL pulse overrun for one cycle; no swap, state unchanged; the swap occurs on the first vb_edge in WAIT_VB.
REQ-015 A draw_done coinciding with vb_edge in DRAW SHALL go to WAIT_VB and pulse overrun; the swap waits for the next edge.
REQ-016 draw_done outside DRAW SHALL be ignored.
REQ-017 In IDLE and WAIT_VB, fb_we=0; fb_x, fb_y and fb_color SHALL hold their last value.
REQ-018 draw_go and overrun SHALL be registered, single-cycle outputs.

Reset
REQ-019 Reset_n low SHALL asynchronously force state IDLE, buffer_sel=0, frame_count=0, draw_go=0, overrun=0, fb_we=0, fb_x=0, fb_y=0, fb_color=0, clear counters 0 and edge history 0.
REQ-020 A reset asserted mid-CLEAR or mid-DRAW SHALL abandon the frame; after release the block waits in IDLE for a fresh vb_edge and does not treat a vblank level high at release as an edge.

Verification
REQ-021 Reset release, then vblank rises: CLEAR starts; W*H=76800 consecutive fb_we cycles with fb_color=0x00, addresses from (0,0) to (319,239) in raster order; then one draw_go pulse.
REQ-022 In DRAW, drive draw_x=5, draw_y=7, draw_color=0x3C, draw_we=1 for one cycle: fb_* match in the same cycle; draw_done then the next vblank edge gives buffer_sel 0->1 and frame_count=1.
REQ-023 Withhold draw_done across one vblank edge: overrun pulses once, buffer_sel is unchanged; draw_done then the next edge produces the swap.
REQ-024 Assert draw_done and the vblank edge in the same cycle: state WAIT_VB, overrun=1, no swap until the next edge.
REQ-025 Assert Reset_n low mid-CLEAR at pixel (100,50) while vblank is high: all outputs reset at once; after release no CLEAR until vblank falls and rises again.
REQ-026 Preload frame_count to 0xFFFF (force), then swap: frame_count=0x0000 and buffer_sel toggles.
